// File: rtl/counter_cmd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | counter_cmd_pkg : command/state encodings and idle-drive levels            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package counter_cmd_pkg;

   typedef enum logic [1:0] {
      OP_LOAD = 2'b00,
      OP_UP   = 2'b01,
      OP_DOWN = 2'b10,
      OP_HOLD = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_EXEC  = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   localparam logic IDLE_LD_CNT    = 1'b1;
   localparam logic IDLE_UPDN_CNT  = 1'b1;
   localparam logic IDLE_COUNT_ENB = 1'b0;

endpackage
`default_nettype wire

// File: rtl/counter_ref_model.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | counter_ref_model : shadow of the up/down load counter plus comparator     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module counter_ref_model #(
   parameter int WIDTH = 16,
   parameter int ERR_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ld_cnt,
   input  logic             updn_cnt,
   input  logic             count_enb,
   input  logic [WIDTH-1:0] data_in,
   input  logic [WIDTH-1:0] data_out,
   output logic             mismatch,
   output logic [ERR_W-1:0] err_cnt,
   output logic [WIDTH-1:0] exp_value
);

   localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

   logic [WIDTH-1:0] exp_q, exp_d;
   logic             arm_q, arm_d;
   logic             mismatch_q, mismatch_d;
   logic [ERR_W-1:0] err_q, err_d;

   always_comb begin
      exp_d = exp_q;
      if (!ld_cnt) begin
         exp_d = data_in;
      end else if (count_enb) begin
         exp_d = updn_cnt ? exp_q + 1'b1 : exp_q - 1'b1;
      end
      arm_d = 1'b1;
      // exp_q already reflects the drive applied one edge earlier, like data_out
      mismatch_d = arm_q && (data_out != exp_q);
      err_d      = err_q;
      if (mismatch_d && (err_q != ERR_MAX)) begin
         err_d = err_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_q      <= '0;
         arm_q      <= 1'b0;
         mismatch_q <= 1'b0;
         err_q      <= '0;
      end else begin
         exp_q      <= exp_d;
         arm_q      <= arm_d;
         mismatch_q <= mismatch_d;
         err_q      <= err_d;
      end
   end

   assign exp_value = exp_q;
   assign mismatch  = mismatch_q;
   assign err_cnt   = err_q;

endmodule
`default_nettype wire

// File: rtl/counter_cmd_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | counter_cmd_driver : valid/ready command initiator for up/down counter     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module counter_cmd_driver
   import counter_cmd_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int ERR_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_arg,
   output logic             ld_cnt,
   output logic             updn_cnt,
   output logic             count_enb,
   output logic [WIDTH-1:0] data_in,
   input  logic [WIDTH-1:0] data_out,
   output logic             busy,
   output logic             mismatch,
   output logic [ERR_W-1:0] err_cnt,
   output logic [WIDTH-1:0] exp_value
);

   localparam logic [WIDTH-1:0] REM_ONE = WIDTH'(1);

   state_e           state_q, state_d;
   op_e              op_q, op_d;
   logic [WIDTH-1:0] arg_q, arg_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             cmd_ready_q, cmd_ready_d;
   logic             busy_q, busy_d;
   logic             ld_cnt_q, ld_cnt_d;
   logic             updn_cnt_q, updn_cnt_d;
   logic             count_enb_q, count_enb_d;
   logic [WIDTH-1:0] data_in_q, data_in_d;
   logic             accept;

   assign accept = cmd_valid && cmd_ready_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_LOAD;
         arg_q       <= '0;
         rem_q       <= '0;
         cmd_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         ld_cnt_q    <= IDLE_LD_CNT;
         updn_cnt_q  <= IDLE_UPDN_CNT;
         count_enb_q <= IDLE_COUNT_ENB;
         data_in_q   <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         arg_q       <= arg_d;
         rem_q       <= rem_d;
         cmd_ready_q <= cmd_ready_d;
         busy_q      <= busy_d;
         ld_cnt_q    <= ld_cnt_d;
         updn_cnt_q  <= updn_cnt_d;
         count_enb_q <= count_enb_d;
         data_in_q   <= data_in_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      arg_d   = arg_q;
      rem_d   = rem_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_EXEC;
               op_d    = op_e'(cmd_op);
               arg_d   = cmd_arg;
               // LOAD and zero-length commands occupy exactly one EXEC cycle
               rem_d   = ((op_e'(cmd_op) == OP_LOAD) || (cmd_arg == '0)) ? REM_ONE : cmd_arg;
            end
         end
         ST_EXEC: begin
            if (rem_q == REM_ONE) begin
               state_d = ST_DRAIN;
            end else begin
               rem_d = rem_q - 1'b1;
            end
         end
         ST_DRAIN: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Drive for the coming cycle is decoded from the next state so pins align with EXEC
   always_comb begin
      ld_cnt_d    = IDLE_LD_CNT;
      updn_cnt_d  = IDLE_UPDN_CNT;
      count_enb_d = IDLE_COUNT_ENB;
      data_in_d   = '0;
      cmd_ready_d = (state_d == ST_IDLE);
      busy_d      = (state_d != ST_IDLE);
      if (state_d == ST_EXEC) begin
         case (op_d)
            OP_LOAD: begin
               ld_cnt_d  = 1'b0;
               data_in_d = arg_d;
            end
            OP_UP, OP_DOWN: begin
               if (arg_d != '0) begin
                  count_enb_d = 1'b1;
                  updn_cnt_d  = (op_d == OP_UP);
               end
            end
            default: ;
         endcase
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign busy      = busy_q;
   assign ld_cnt    = ld_cnt_q;
   assign updn_cnt  = updn_cnt_q;
   assign count_enb = count_enb_q;
   assign data_in   = data_in_q;

   counter_ref_model #(
      .WIDTH (WIDTH),
      .ERR_W (ERR_W)
   ) u_ref (
      .clk       (clk),
      .rst       (rst),
      .ld_cnt    (ld_cnt_q),
      .updn_cnt  (updn_cnt_q),
      .count_enb (count_enb_q),
      .data_in   (data_in_q),
      .data_out  (data_out),
      .mismatch  (mismatch),
      .err_cnt   (err_cnt),
      .exp_value (exp_value)
   );

endmodule
`default_nettype wire

// File: tb/tb_counter_cmd_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_counter_cmd_driver : directed bench with cycle-queue model of driver    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_counter_cmd_driver;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_op = 2'b00;
   logic [15:0] cmd_arg = 16'h0;
   logic        ld_cnt, updn_cnt, count_enb;
   logic [15:0] data_in, data_out;
   logic        busy, mismatch;
   logic [7:0]  err_cnt;
   logic [15:0] exp_value;

   logic [15:0] cnt_q;
   logic [15:0] force_off = 16'h0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   counter_cmd_driver #(.WIDTH(16), .ERR_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_arg   (cmd_arg),
      .ld_cnt    (ld_cnt),
      .updn_cnt  (updn_cnt),
      .count_enb (count_enb),
      .data_in   (data_in),
      .data_out  (data_out),
      .busy      (busy),
      .mismatch  (mismatch),
      .err_cnt   (err_cnt),
      .exp_value (exp_value)
   );

   // The counter being driven; force_off corrupts its visible output
   always_ff @(posedge clk or posedge rst) begin
      if (rst)           cnt_q <= 16'h0;
      else if (!ld_cnt)  cnt_q <= data_in;
      else if (count_enb) cnt_q <= updn_cnt ? cnt_q + 16'd1 : cnt_q - 16'd1;
   end
   assign data_out = cnt_q + force_off;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Model: each accepted command expands to a list of per-cycle drives plus a drain cycle
   typedef struct packed {
      logic        ld;
      logic        updn;
      logic        enb;
      logic [15:0] din;
   } drv_t;

   drv_t        sched[$];
   logic        m_ready = 1'b1, m_busy = 1'b0;
   logic        m_ld = 1'b1, m_updn = 1'b1, m_enb = 1'b0;
   logic [15:0] m_din = 16'h0, m_exp = 16'h0, m_nexp;
   logic        m_mis = 1'b0, m_armed = 1'b0;
   int          m_err = 0;
   drv_t        m_cur;

   task automatic expand(input logic [1:0] op, input logic [15:0] arg);
      drv_t idle_d = '{ld: 1'b1, updn: 1'b1, enb: 1'b0, din: 16'h0};
      drv_t cnt_d  = '{ld: 1'b1, updn: (op == 2'b01), enb: 1'b1, din: 16'h0};
      int   n      = (arg == 16'h0) ? 1 : int'(arg);
      if (op == 2'b00) begin
         sched.push_back('{ld: 1'b0, updn: 1'b1, enb: 1'b0, din: arg});
      end else begin
         for (int i = 0; i < n; i++)
            sched.push_back((op != 2'b11 && arg != 16'h0) ? cnt_d : idle_d);
      end
      sched.push_back(idle_d);
   endtask

   always @(negedge clk) begin
      if (rst) begin
         sched.delete();
         m_ready = 1'b1; m_busy = 1'b0; m_ld = 1'b1; m_updn = 1'b1; m_enb = 1'b0;
         m_din = 16'h0; m_exp = 16'h0; m_mis = 1'b0; m_err = 0; m_armed = 1'b0;
      end
      check("cmd_ready", cmd_ready, m_ready);
      check("busy",      busy,      m_busy);
      check("ld_cnt",    ld_cnt,    m_ld);
      check("updn_cnt",  updn_cnt,  m_updn);
      check("count_enb", count_enb, m_enb);
      check("data_in",   data_in,   m_din);
      check("exp_value", exp_value, m_exp);
      check("mismatch",  mismatch,  m_mis);
      check("err_cnt",   err_cnt,   m_err);
      if (!rst) begin
         if (cmd_valid && m_ready) expand(cmd_op, cmd_arg);
         m_nexp = m_exp;
         if (!m_ld)      m_nexp = m_din;
         else if (m_enb) m_nexp = m_updn ? m_exp + 16'd1 : m_exp - 16'd1;
         m_mis = m_armed && (data_out != m_exp);
         if (m_mis && m_err < 255) m_err++;
         m_exp   = m_nexp;
         m_armed = 1'b1;
         if (sched.size() > 0) begin
            m_cur  = sched.pop_front();
            m_busy = 1'b1;
         end else begin
            m_cur  = '{ld: 1'b1, updn: 1'b1, enb: 1'b0, din: 16'h0};
            m_busy = 1'b0;
         end
         m_ready = !m_busy;
         m_ld = m_cur.ld; m_updn = m_cur.updn; m_enb = m_cur.enb; m_din = m_cur.din;
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Leaves cmd_valid high so consecutive calls model a held request stream
   task automatic send(input logic [1:0] op, input logic [15:0] arg);
      bit acc = 1'b0;
      cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
      for (int i = 0; i < 64 && !acc; i++) begin
         @(negedge clk);
         acc = cmd_ready;
         @(posedge clk);
         #1;
      end
      check("accept_within_bound", acc, 1'b1);
   endtask

   task automatic finish_cmds();
      bit rdy = 1'b0;
      cmd_valid = 1'b0;
      for (int i = 0; i < 64 && !rdy; i++) begin
         @(negedge clk);
         rdy = cmd_ready;
      end
      check("idle_within_bound", rdy, 1'b1);
      cycles(2);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
      $fatal(1);
   end

   initial begin
      @(negedge clk);
      check("rst_ready",  cmd_ready, 1'b1);
      check("rst_exp",    exp_value, 16'h0);
      check("rst_ld_cnt", ld_cnt,    1'b1);
      @(posedge clk); #1;
      rst = 1'b0;
      cycles(2);

      // LOAD then UP 3
      send(2'b00, 16'h1234);
      send(2'b01, 16'd3);
      finish_cmds();
      check("t2_exp",      exp_value, 16'h1237);
      check("t2_data_out", data_out,  16'h1237);
      check("t2_err",      err_cnt,   8'h00);

      // Wrap up through zero, then back down
      send(2'b00, 16'hFFFE);
      send(2'b01, 16'd3);
      finish_cmds();
      check("t3_up_wrap", exp_value, 16'h0001);
      send(2'b10, 16'd2);
      finish_cmds();
      check("t3_down_wrap", exp_value, 16'hFFFF);
      send(2'b01, 16'd0);
      finish_cmds();
      check("up_zero_len", exp_value, 16'hFFFF);
      check("t3_err",      err_cnt,   8'h00);

      // One corrupted cycle during HOLD
      send(2'b11, 16'd10);
      cycles(3);
      force_off = 16'h0001;
      cycles(1);
      force_off = 16'h0000;
      finish_cmds();
      check("t4_err", err_cnt, 8'h01);

      // Held valid with three queued LOADs
      send(2'b00, 16'h00A1);
      send(2'b00, 16'h00B2);
      send(2'b00, 16'h00C3);
      finish_cmds();
      check("t5_exp", exp_value, 16'h00C3);

      // Persistent corruption saturates the error count
      force_off = 16'h0100;
      cycles(300);
      force_off = 16'h0000;
      cycles(2);
      check("t6_err_sat",  err_cnt,  8'hFF);
      check("t6_mis_gone", mismatch, 1'b0);

      // Reset in the middle of UP 5
      send(2'b00, 16'h0050);
      send(2'b01, 16'd5);
      cycles(2);
      rst = 1'b1;
      @(negedge clk);
      check("t1_ld_cnt",    ld_cnt,    1'b1);
      check("t1_count_enb", count_enb, 1'b0);
      check("t1_exp",       exp_value, 16'h0);
      check("t1_err",       err_cnt,   8'h00);
      check("t1_ready",     cmd_ready, 1'b1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      rst = 1'b0;
      cycles(3);
      send(2'b00, 16'h0007);
      finish_cmds();
      check("t1_after_exp", exp_value, 16'h0007);
      check("t1_after_err", err_cnt,   8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
